// File: rtl/poly3_serializer_if.sv
// Block-in / sample-out stream bundle for poly3_serializer.
// The slave side is the serializer; the master side is its environment.
interface poly3_serializer_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32
);
  logic                    blk_valid;
  logic                    blk_ready;
  logic signed [IN_W-1:0]  y0;
  logic signed [IN_W-1:0]  y1;
  logic signed [IN_W-1:0]  y2;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output blk_valid, y0, y1, y2, out_ready,
    input  blk_ready, out_data, out_valid
  );

  modport slave (
    input  blk_valid, y0, y1, y2, out_ready,
    output blk_ready, out_data, out_valid
  );
endinterface

// File: rtl/poly3_serializer.sv
// Buffers 3-lane FIR output blocks and emits them one sample per transfer, in time order.
// Define POLY3_SERIALIZER_SAT_EN for per-lane saturation; otherwise lanes wrap by truncation.
module poly3_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  poly3_serializer_if.slave      s,
  input  logic                   clr_flags,
  output logic                   sat_flag,
  output logic                   drop_flag,
  output logic [$clog2(DEPTH):0] fill
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {LANE0, LANE1, LANE2} state_t;

  state_t                 state, state_nxt;
  logic [2:0][OUT_W-1:0]  mem [DEPTH];
  logic [2:0][OUT_W-1:0]  head;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [IN_W-1:0]        lane_in [3];
  logic [2:0][OUT_W-1:0]  lanes;
  logic [2:0]             clip;
  logic                   rdy, vld, push, pop, xfer, drop;

  always_comb begin
    lane_in[0] = s.y0;
    lane_in[1] = s.y1;
    lane_in[2] = s.y2;
  end

`ifdef POLY3_SERIALIZER_SAT_EN
  always_comb begin
    lanes = '0;
    clip  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      // In range exactly when every bit above the output sign bit replicates it.
      clip[i] = !((&lane_in[i][IN_W-1:OUT_W-1]) || !(|lane_in[i][IN_W-1:OUT_W-1]));
      if (!clip[i])
        lanes[i] = lane_in[i][OUT_W-1:0];
      else if (lane_in[i][IN_W-1])
        lanes[i] = {1'b1, {(OUT_W-1){1'b0}}};
      else
        lanes[i] = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;

  always_comb begin
    lanes = '0;
    clip  = '0;
    for (int unsigned i = 0; i < 3; i++)
      lanes[i] = lane_in[i][OUT_W-1:0];
  end

  assign unused_hi = ^{lane_in[0][IN_W-1:OUT_W], lane_in[1][IN_W-1:OUT_W],
                       lane_in[2][IN_W-1:OUT_W]};
`endif

  // Ready looks only at the registered fill, so a same-cycle pop never admits a push.
  always_comb begin
    rdy  = fill < FULL;
    vld  = fill != '0;
    push = s.blk_valid && rdy;
    drop = s.blk_valid && !rdy;
    xfer = vld && s.out_ready;
    pop  = xfer && (state == LANE2);
    head = mem[rd_ptr];

    state_nxt = state;
    case (state)
      LANE0:   if (xfer) state_nxt = LANE1;
      LANE1:   if (xfer) state_nxt = LANE2;
      LANE2:   if (xfer) state_nxt = LANE0;
      default: state_nxt = LANE0;
    endcase

    s.out_data = '0;
    if (vld) begin
      case (state)
        LANE0:   s.out_data = head[0];
        LANE1:   s.out_data = head[1];
        LANE2:   s.out_data = head[2];
        default: s.out_data = '0;
      endcase
    end
    s.out_valid = vld;
    s.blk_ready = rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LANE0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (push && (|clip)) sat_flag <= 1'b1;
      else if (clr_flags)  sat_flag <= 1'b0;
      if (drop)            drop_flag <= 1'b1;
      else if (clr_flags)  drop_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lanes;
  end
endmodule

// File: tb/tb_poly3_serializer.sv
// Randomized self-checking bench for poly3_serializer against a sample-queue reference model.
module tb_poly3_serializer;
  localparam int IN_W = 64, OUT_W = 32, DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_flags;
  logic       sat_flag, drop_flag;
  logic [2:0] fill;

  poly3_serializer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  poly3_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s(bus), .clr_flags(clr_flags),
    .sat_flag(sat_flag), .drop_flag(drop_flag), .fill(fill)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // Model: flat queue of pending samples in emission order; a block counts while any sample remains.
  logic [31:0] mq[$];
  bit          m_sat, m_drop;

  logic [38:0] dut_vec;
  assign dut_vec = {bus.out_valid, bus.blk_ready, fill, sat_flag, drop_flag, bus.out_data};

  function automatic int m_fill();
    return (mq.size() + 2) / 3;
  endfunction

  function automatic logic [38:0] exp_vec();
    logic [31:0] d;
    d = (mq.size() != 0) ? mq[0] : 32'd0;
    return {mq.size() != 0, m_fill() < DEPTH, 3'(m_fill()), m_sat, m_drop, d};
  endfunction

  function automatic logic [31:0] conv(input logic signed [63:0] v, output bit clip);
    clip = 1'b0;
`ifdef POLY3_SERIALIZER_SAT_EN
    if (v > 64'sd2147483647) begin
      clip = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (v < -64'sd2147483648) begin
      clip = 1'b1;
      return 32'h8000_0000;
    end
`endif
    return v[31:0];
  endfunction

  function automatic logic [63:0] rnd_val();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {{32{r[31]}}, r};
      1:       return {$urandom, $urandom};
      2:       return 64'h0000_0000_7FFF_FFFF;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return 64'h0000_0000_8000_0000;
      default: return 64'hFFFF_FFFF_7FFF_FFFF;
    endcase
  endfunction

  task automatic idle();
    bus.blk_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.y0 = '0; bus.y1 = '0; bus.y2 = '0;
    clr_flags = 1'b0;
  endtask

  task automatic set_blk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bus.blk_valid = 1'b1;
    bus.y0 = a; bus.y1 = b; bus.y2 = c;
  endtask

  task automatic set_rnd_blk();
    set_blk(rnd_val(), rnd_val(), rnd_val());
  endtask

  // Advance one clock edge, updating the model from the inputs presented at that edge.
  task automatic cycle();
    bit xfer, accept, offered, c0, c1, c2;
    logic [31:0] s0, s1, s2;
    xfer    = (mq.size() != 0) && bus.out_ready;
    offered = bus.blk_valid;
    accept  = offered && (m_fill() < DEPTH);
    s0 = conv(bus.y0, c0);
    s1 = conv(bus.y1, c1);
    s2 = conv(bus.y2, c2);
    @(posedge clk);
    if (xfer) void'(mq.pop_front());
    if (accept) begin
      mq.push_back(s0); mq.push_back(s1); mq.push_back(s2);
    end
    if (accept && (c0 || c1 || c2)) m_sat = 1'b1;
    else if (clr_flags)             m_sat = 1'b0;
    if (offered && !accept)         m_drop = 1'b1;
    else if (clr_flags)             m_drop = 1'b0;
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_sat = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec !== 39'h20_0000_0000) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec, 39'h20_0000_0000);
    end
    rst = 1'b0;
    cycle();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    logic [31:0] want [3];
    want[0] = 32'd1; want[1] = 32'hFFFF_FFFE; want[2] = 32'd3;
    set_blk(64'sd1, -64'sd2, 64'sd3);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      bus.blk_valid = 1'b0;
      n_cmp++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, want[i]}) begin
        n_fail++; $display("FAIL basic_lane%0d: got %b/%h want 1/%h", i, bus.out_valid, bus.out_data, want[i]);
      end
    end
    cycle();
    n_cmp++;
    if ({bus.out_valid, fill, sat_flag} !== 5'b0_000_0) begin
      n_fail++; $display("FAIL basic_empty: got v=%b fill=%0d sat=%b want 0/0/0", bus.out_valid, fill, sat_flag);
    end
  endtask

  task automatic test_sat();
    logic [31:0] want [3];
    logic        want_sat;
`ifdef POLY3_SERIALIZER_SAT_EN
    want[0] = 32'h7FFF_FFFF; want[1] = 32'h8000_0000; want[2] = 32'h7FFF_FFFF; want_sat = 1'b1;
`else
    want[0] = 32'h0; want[1] = 32'h0; want[2] = 32'h7FFF_FFFF; want_sat = 1'b0;
`endif
    set_blk(64'sd1 <<< 40, -(64'sd1 <<< 40), 64'h7FFF_FFFF);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      bus.blk_valid = 1'b0;
      n_cmp++;
      if (bus.out_data !== want[i]) begin
        n_fail++; $display("FAIL sat_lane%0d: got %h want %h", i, bus.out_data, want[i]);
      end
    end
    n_cmp++;
    if (sat_flag !== want_sat) begin
      n_fail++; $display("FAIL sat_flag: got %b want %b", sat_flag, want_sat);
    end
    cycle();
    clr_flags = 1'b1;
    cycle();
    clr_flags = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec() || sat_flag !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_full_drop();
    idle();
    for (int i = 0; i < 5; i++) begin
      set_rnd_blk();
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL fill_push%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (i == 3) begin
        n_cmp++;
        if ({fill, bus.blk_ready, drop_flag} !== 5'b100_0_0) begin
          n_fail++; $display("FAIL full_state: got fill=%0d rdy=%b drop=%b want 4/0/0", fill, bus.blk_ready, drop_flag);
        end
      end
    end
    n_cmp++;
    if ({fill, drop_flag} !== 4'b100_1) begin
      n_fail++; $display("FAIL drop_set: got fill=%0d drop=%b want 4/1", fill, drop_flag);
    end
    bus.blk_valid = 1'b0;
    clr_flags = 1'b1;
    cycle();
    clr_flags = 1'b0;
    n_cmp++;
    if (drop_flag !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL drop_clear: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  // Entered with a full FIFO; two more blocks are pushed as space opens, crossing the pointer wrap.
  task automatic test_stall_wrap();
    int pushed = 0;
    for (int i = 0; i < 48; i++) begin
      bus.out_ready = (i % 2 == 0);
      if (pushed < 2 && m_fill() < DEPTH) begin
        set_rnd_blk();
        pushed++;
      end else begin
        bus.blk_valid = 1'b0;
      end
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL stall_cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    idle();
    n_cmp++;
    if ({bus.out_valid, fill} !== 4'b0_000) begin
      n_fail++; $display("FAIL stall_drained: got v=%b fill=%0d want 0/0", bus.out_valid, fill);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] nv;
    idle();
    set_rnd_blk();
    cycle();
    bus.blk_valid = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    nv = 64'sd12345 - 64'(int'($urandom_range(0, 1000)));
    set_blk(nv, rnd_val(), rnd_val());
    cycle();
    bus.blk_valid = 1'b0;
    n_cmp++;
    if ({fill, bus.out_data} !== {3'd1, nv[31:0]}) begin
      n_fail++; $display("FAIL b2b_swap: got fill=%0d data=%h want 1/%h", fill, bus.out_data, nv[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_drain%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] nv;
    idle();
    for (int i = 0; i < 3; i++) begin
      set_rnd_blk();
      cycle();
    end
    bus.blk_valid = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL midrst_pre: got %h want %h", dut_vec, exp_vec());
    end
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.out_valid, fill, bus.blk_ready} !== 5'b0_000_1) begin
      n_fail++; $display("FAIL midrst_async: got v=%b fill=%0d rdy=%b want 0/0/1", bus.out_valid, fill, bus.blk_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    nv = 64'sd777;
    set_blk(nv, 64'sd8, 64'sd9);
    bus.out_ready = 1'b1;
    cycle();
    bus.blk_valid = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.out_data, fill} !== {1'b1, 32'd777, 3'd1}) begin
      n_fail++; $display("FAIL midrst_fresh: got v=%b data=%h fill=%0d want 1/309/1", bus.out_valid, bus.out_data, fill);
    end
    cycle();
    cycle();
    cycle();
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clr_flags     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) set_rnd_blk();
      else bus.blk_valid = 1'b0;
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL rand_cyc%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_full_drop();
    test_stall_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
